// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - groups multiplier products into sums over valid/ready handshakes
// Sums up to COUNT products per group and presents sum, count and a sticky carry-out flag.
module product_accumulator #(
    parameter int n     = 16,
    parameter int COUNT = 4,
    parameter int G     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*n-1:0]               Z,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [2*n+G-1:0]             sum,
    output logic [$clog2(COUNT+1)-1:0]   sum_cnt,
    output logic                         ovf,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int W  = 2*n + G;
    localparam int CW = $clog2(COUNT+1);
    localparam logic [CW-1:0] LAST = CW'(COUNT-1);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gflag_q, gflag_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   sum_cnt_q, sum_cnt_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            close;
    logic [W:0]      add;
    logic [W-1:0]    acc_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            gflag_nxt;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        gflag_d   = gflag_q;
        sum_d     = sum_q;
        sum_cnt_d = sum_cnt_q;
        ovf_d     = ovf_q;

        accept    = in_valid && (state_q == ST_ACC);
        add       = {1'b0, acc_q} + {{(G+1){1'b0}}, Z};
        acc_nxt   = accept ? add[W-1:0] : acc_q;
        cnt_nxt   = accept ? cnt_q + 1'b1 : cnt_q;
        gflag_nxt = gflag_q | (accept & add[W]);
        // A lone flush on an empty group must not emit anything.
        close     = (state_q == ST_ACC) &&
                    ((accept && cnt_q == LAST) || (flush && (cnt_q != '0 || accept)));

        case (state_q)
            ST_ACC: begin
                if (close) begin
                    sum_d     = acc_nxt;
                    sum_cnt_d = cnt_nxt;
                    ovf_d     = gflag_nxt;
                    acc_d     = '0;
                    cnt_d     = '0;
                    gflag_d   = 1'b0;
                    state_d   = ST_HOLD;
                end else begin
                    acc_d     = acc_nxt;
                    cnt_d     = cnt_nxt;
                    gflag_d   = gflag_nxt;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            gflag_q   <= 1'b0;
            sum_q     <= '0;
            sum_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            gflag_q   <= gflag_d;
            sum_q     <= sum_d;
            sum_cnt_q <= sum_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign sum       = sum_q;
    assign sum_cnt   = sum_cnt_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] z;
    logic        in_valid, flush, out_ready;
    logic        in_ready, ovf, out_valid;
    logic [35:0] sum;
    logic [2:0]  sum_cnt;

    logic [31:0] z2;
    logic        in_valid2, flush2, out_ready2;
    logic        in_ready2, ovf2, out_valid2;
    logic [32:0] sum2;
    logic [2:0]  sum_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    product_accumulator #(.n(16), .COUNT(4), .G(4)) dut (
        .clk(clk), .rst(rst), .Z(z), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .sum(sum), .sum_cnt(sum_cnt), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    product_accumulator #(.n(16), .COUNT(4), .G(1)) dut_g1 (
        .clk(clk), .rst(rst), .Z(z2), .in_valid(in_valid2), .in_ready(in_ready2),
        .flush(flush2), .sum(sum2), .sum_cnt(sum_cnt2), .ovf(ovf2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val, input logic fl);
        z = val; in_valid = 1'b1; flush = fl;
        cyc();
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; z = '0; in_valid = 0; flush = 0; out_ready = 1;
        z2 = '0; in_valid2 = 0; flush2 = 0; out_ready2 = 1;
        cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_cnt", sum_cnt, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // T1
        send(6000, 0); send(888, 0); send(960, 0);
        check("t1_no_early_out", out_valid, 0);
        send(2048, 0);
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready", in_ready, 0);
        check("t1_sum", sum, 9896);
        check("t1_cnt", sum_cnt, 4);
        check("t1_ovf", ovf, 0);
        cyc();
        check("t1_release", out_valid, 0);
        check("t1_in_ready_back", in_ready, 1);
        check("t1_sum_kept", sum, 9896);

        // T2
        send(12000, 0);
        flush = 1; cyc(); flush = 0;
        check("t2_out_valid", out_valid, 1);
        check("t2_sum", sum, 12000);
        check("t2_cnt", sum_cnt, 1);
        check("t2_ovf", ovf, 0);
        cyc();
        flush = 1; cyc(); flush = 0;
        check("t2_empty_flush", out_valid, 0);
        cyc();
        check("t2_empty_flush2", out_valid, 0);

        // T3
        out_ready = 0;
        send(100, 1);
        check("t3_out_valid", out_valid, 1);
        z = 5000; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t3_in_ready_low", in_ready, 0);
            check("t3_sum_stable", sum, 100);
        end
        out_ready = 1;
        cyc();
        check("t3_back_acc", out_valid, 0);
        cyc();
        z = 7; flush = 1; cyc(); in_valid = 0; flush = 0;
        check("t3_new_valid", out_valid, 1);
        check("t3_new_sum", sum, 5007);
        check("t3_new_cnt", sum_cnt, 2);
        cyc();

        // T5
        send(1000, 0); send(2000, 0);
        check("t5_no_out", out_valid, 0);
        rst = 1; cyc(); rst = 0;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_sum", sum, 0);
        send(6000, 0); send(888, 0); send(960, 0); send(2048, 0);
        check("t5_sum", sum, 9896);
        check("t5_cnt", sum_cnt, 4);
        check("t5_valid", out_valid, 1);
        cyc();

        // T6
        send(6000, 0); send(888, 1);
        check("t6_valid", out_valid, 1);
        check("t6_sum", sum, 6888);
        check("t6_cnt", sum_cnt, 2);
        cyc();

        // T4
        z2 = 32'hFFFE0001; in_valid2 = 1;
        cyc(); cyc(); cyc();
        check("t4_no_early_out", out_valid2, 0);
        cyc();
        in_valid2 = 0;
        check("t4_valid", out_valid2, 1);
        check("t4_ovf", ovf2, 1);
        check("t4_sum", sum2, 64'h1FFF80004);
        check("t4_cnt", sum_cnt2, 4);
        cyc();
        check("t4_release", out_valid2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
